// File: rtl/cordic_cmd_ctrl.sv
// Bus-mapped command front end for the CORDIC coprocessor: angle reduction/fold, issue, wait, sign fix.
// Optional completion interrupt enabled by defining CORDIC_CMD_IRQ_EN.
module cordic_cmd_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int FULL_TURN = 360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [15:0] cordic_angle,
  output logic [15:0] cordic_another,
  output logic [3:0]  cordic_select,
  output logic        cordic_valid,
  input  logic [15:0] cordic_out,
  input  logic        cordic_out_valid,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_FOLD, S_ISSUE, S_WAIT, S_FIX, S_DONE
  } state_e;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [16:0] TURN = 17'(FULL_TURN);
  localparam logic signed [16:0] QTR  = 17'(FULL_TURN / 4);
  localparam logic signed [16:0] HALF = 17'(FULL_TURN / 2);
  localparam logic signed [16:0] TQTR = 17'(3 * FULL_TURN / 4);

  state_e             state_q, state_d;
  logic [15:0]        angle_q, another_q, cap_q, result_q, rdata_q;
  logic [15:0]        cang_q, canother_q;
  logic [3:0]         sel_q, csel_q;
  logic signed [16:0] a_q;
  logic [1:0]         quad_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q, err_q;

  logic        wr_idle, start, sel_ok, a_in_range, timeout_hit, neg, irq_bit;
  logic [3:0]  sel_w;
  logic [15:0] fold_a, neg_val;
  logic [1:0]  fold_quad;

  assign wr_idle     = wr_en && (state_q == S_IDLE);
  assign start       = wr_idle && (addr == 2'd2) && wdata[8];
  assign sel_w       = wdata[3:0];
  assign sel_ok      = (sel_w != 4'd0) && ((sel_w & (sel_w - 4'd1)) == 4'd0);
  assign a_in_range  = !a_q[16] && (a_q < TURN);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = !sel_ok ? S_DONE : (sel_w[3] ? S_ISSUE : S_REDUCE);
      S_REDUCE: if (a_in_range) state_d = S_FOLD;
      S_FOLD:   state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (cordic_out_valid) state_d = S_FIX;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_FIX:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; cordic_valid decodes the state so reset kills it immediately
  always_comb begin
    cordic_valid = 1'b0;
    busy         = 1'b0;
    case (state_q)
      S_ISSUE:                   begin cordic_valid = 1'b1; busy = 1'b1; end
      S_REDUCE, S_FOLD, S_WAIT,
      S_FIX:                     busy = 1'b1;
      default: ;
    endcase
  end

  // Fold a reduced angle in [0, FULL_TURN) into the first quadrant
  always_comb begin
    fold_a    = a_q[15:0];
    fold_quad = 2'd0;
    if (a_q <= QTR) begin
      fold_a = a_q[15:0];            fold_quad = 2'd0;
    end else if (a_q <= HALF) begin
      fold_a = 16'(HALF - a_q);      fold_quad = 2'd1;
    end else if (a_q <= TQTR) begin
      fold_a = 16'(a_q - HALF);      fold_quad = 2'd2;
    end else begin
      fold_a = 16'(TURN - a_q);      fold_quad = 2'd3;
    end
  end

  // sin negative in q2/q3, cos in q1/q2, tan in q1/q3; arctan keeps quad 0
  assign neg     = (sel_q[0] && quad_q[1]) ||
                   (sel_q[1] && (quad_q == 2'd1 || quad_q == 2'd2)) ||
                   (sel_q[2] && quad_q[0]);
  assign neg_val = (cap_q == 16'h8000) ? 16'h7FFF : (~cap_q + 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_q <= '0; another_q <= '0; sel_q <= '0; a_q <= '0; quad_q <= '0;
      cnt_q <= '0; cap_q <= '0; result_q <= '0; done_q <= 1'b0; err_q <= 1'b0;
      cang_q <= '0; canother_q <= '0; csel_q <= '0; rdata_q <= '0;
    end else begin
      if (wr_idle) begin
        case (addr)
          2'd0:    angle_q   <= wdata;
          2'd1:    another_q <= wdata;
          2'd2:    sel_q     <= sel_w;
          default: ;
        endcase
      end
      if (start) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        a_q    <= {angle_q[15], angle_q};
        quad_q <= 2'd0;
        if (!sel_ok) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else if (sel_w[3]) begin
          cang_q     <= angle_q;
          canother_q <= another_q;
          csel_q     <= sel_w;
        end
      end
      case (state_q)
        S_REDUCE: begin
          if (a_q[16])         a_q <= a_q + TURN;
          else if (a_q >= TURN) a_q <= a_q - TURN;
        end
        S_FOLD: begin
          cang_q     <= fold_a;
          quad_q     <= fold_quad;
          canother_q <= another_q;
          csel_q     <= sel_q;
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          if (cordic_out_valid) cap_q <= cordic_out;
          else if (timeout_hit) begin
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            result_q <= 16'h0000;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          result_q <= neg ? neg_val : cap_q;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
      if (rd_en) begin
        case (addr)
          2'd0:    rdata_q <= angle_q;
          2'd1:    rdata_q <= another_q;
          2'd2:    rdata_q <= {12'b0, irq_bit, busy, err_q, done_q};
          default: rdata_q <= result_q;
        endcase
      end
    end
  end

`ifdef CORDIC_CMD_IRQ_EN
  logic irq_en_q, irq_q, irq_en_eff;
  // A start write carries its own enable bit into the same-cycle DONE entry
  assign irq_en_eff = start ? wdata[9] : irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_idle && addr == 2'd2) irq_en_q <= wdata[9];
      if (wr_en && addr == 2'd2 && wdata[15]) irq_q <= 1'b0;
      else if (state_d == S_DONE && state_q != S_DONE && irq_en_eff) irq_q <= 1'b1;
    end
  end
  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq     = 1'b0;
  assign irq_bit = 1'b0;
`endif

  assign rdata          = rdata_q;
  assign cordic_angle   = cang_q;
  assign cordic_another = canother_q;
  assign cordic_select  = csel_q;

endmodule

// File: tb/tb_cordic_cmd_ctrl.sv
// Directed bench for cordic_cmd_ctrl: issue-operand scoreboard plus result/status readback.
module tb_cordic_cmd_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0, cordic_out = '0;
  logic        cordic_out_valid = 1'b0;
  logic [15:0] rdata, cordic_angle, cordic_another;
  logic [3:0]  cordic_select;
  logic        cordic_valid, busy, irq;

  cordic_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cordic_angle(cordic_angle), .cordic_another(cordic_another),
    .cordic_select(cordic_select), .cordic_valid(cordic_valid), .cordic_out(cordic_out),
    .cordic_out_valid(cordic_out_valid), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ang;
    logic [15:0] oth;
    logic [3:0]  sel;
  } op_t;

  op_t         exp_q[$];
  logic [15:0] res_q[$];
  int vectors = 0, miscompares = 0, nvalid = 0;

  always @(posedge clk) if (cordic_valid) nvalid++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk); wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk); rd_en = 1'b1; addr = a;
    @(negedge clk); rd_en = 1'b0; d = rdata;
  endtask

  task automatic start_cmd(input logic [15:0] ang, input logic [15:0] oth, input logic [15:0] ctrl,
                           input op_t eop, input logic [15:0] eres);
    bus_write(2'd0, ang);
    bus_write(2'd1, oth);
    bus_write(2'd2, ctrl);
    exp_q.push_back(eop);
    res_q.push_back(eres);
  endtask

  // Waits for the issue pulse and pops the expected operands for it
  task automatic see_issue(input string tag);
    int n = 0;
    op_t op;
    while (cordic_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_issue"}, 16'(cordic_valid), 16'h0001);
    if (exp_q.size() > 0) begin
      op = exp_q.pop_front();
      check({tag, "_angle"},   cordic_angle,        op.ang);
      check({tag, "_another"}, cordic_another,      op.oth);
      check({tag, "_select"},  16'(cordic_select),  16'(op.sel));
    end
  endtask

  task automatic respond(input logic [15:0] val, input int dly);
    repeat (dly) @(negedge clk);
    cordic_out = val; cordic_out_valid = 1'b1;
    @(negedge clk); cordic_out_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input logic [15:0] exp_stat);
    int n = 0;
    logic [15:0] d, r;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_busy_drop"}, 16'(busy), 16'h0000);
    bus_read(2'd3, d);
    r = (res_q.size() > 0) ? res_q.pop_front() : 16'hxxxx;
    check({tag, "_result"}, d, r);
    bus_read(2'd2, d);
    check({tag, "_status"}, d, exp_stat);
  endtask

  initial begin
    logic [15:0] d, irq_stat;
    int n0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",  16'(cordic_valid),  16'h0);
    check("rst_busy",   16'(busy),          16'h0);
    check("rst_irq",    16'(irq),           16'h0);
    check("rst_angle",  cordic_angle,       16'h0);
    check("rst_select", 16'(cordic_select), 16'h0);
    check("rst_rdata",  rdata,              16'h0);
    rst_n = 1'b1;
    bus_read(2'd2, d); check("rst_status", d, 16'h0000);
    bus_read(2'd3, d); check("rst_result", d, 16'h0000);

    // sin 210 -> q2, fold 30, negate
    n0 = nvalid;
    start_cmd(16'd210, 16'd0, 16'h0101, op_t'{16'd30, 16'd0, 4'b0001}, 16'hFF80);
    see_issue("sin210"); respond(16'h0080, 2); finish_cmd("sin210", 16'h0001);
    check("sin210_pulses", 16'(nvalid - n0), 16'd1);

    // cos -90 -> 270 q2, fold 90
    start_cmd(16'hFFA6, 16'd0, 16'h0102, op_t'{16'd90, 16'd0, 4'b0010}, 16'h0000);
    see_issue("cosm90"); respond(16'h0000, 1); finish_cmd("cosm90", 16'h0001);

    // cos 720 -> 0, q0, no sign change
    start_cmd(16'd720, 16'd0, 16'h0102, op_t'{16'd0, 16'd0, 4'b0010}, 16'h0100);
    see_issue("cos720"); respond(16'h0100, 1); finish_cmd("cos720", 16'h0001);

    // tan 135 -> q1, fold 45, negate; then saturation of 0x8000
    start_cmd(16'd135, 16'd0, 16'h0104, op_t'{16'd45, 16'd0, 4'b0100}, 16'hFF00);
    see_issue("tan135"); respond(16'h0100, 1); finish_cmd("tan135", 16'h0001);
    start_cmd(16'd135, 16'd0, 16'h0104, op_t'{16'd45, 16'd0, 4'b0100}, 16'h7FFF);
    see_issue("tansat"); respond(16'h8000, 1); finish_cmd("tansat", 16'h0001);

    // arctan pass-through
    start_cmd(16'h0100, 16'h0100, 16'h0108, op_t'{16'h0100, 16'h0100, 4'b1000}, 16'h2D00);
    see_issue("atan"); respond(16'h2D00, 3); finish_cmd("atan", 16'h0001);

    // Timeout: exactly TIMEOUT WAIT cycles, then DONE
    start_cmd(16'd10, 16'd0, 16'h0101, op_t'{16'd10, 16'd0, 4'b0001}, 16'h0000);
    see_issue("tmo");
    n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check("tmo_cycles", 16'(n), 16'd65);
    finish_cmd("tmo", 16'h0003);

    // Non-one-hot select: error, no issue
    n0 = nvalid;
    bus_write(2'd2, 16'h0103);
    repeat (5) @(negedge clk);
    bus_read(2'd2, d); check("badsel_status", d, 16'h0003);
    check("badsel_pulses", 16'(nvalid - n0), 16'd0);

    // Writes while busy are ignored (3700 reduces slowly to 100 -> q1, fold 80)
    n0 = nvalid;
    start_cmd(16'd3700, 16'd0, 16'h0101, op_t'{16'd80, 16'd0, 4'b0001}, 16'h0100);
    bus_write(2'd0, 16'd45);
    bus_write(2'd2, 16'h0102);
    see_issue("busyign"); respond(16'h0100, 1); finish_cmd("busyign", 16'h0001);
    check("busyign_pulses", 16'(nvalid - n0), 16'd1);
    bus_write(2'd2, 16'h0101);
    exp_q.push_back(op_t'{16'd80, 16'd0, 4'b0001});
    res_q.push_back(16'h00C0);
    see_issue("keepang"); respond(16'h00C0, 1); finish_cmd("keepang", 16'h0001);

    // Reset during ISSUE: valid drops at once, late result ignored
    start_cmd(16'd30, 16'd0, 16'h0101, op_t'{16'd30, 16'd0, 4'b0001}, 16'h0000);
    void'(res_q.pop_back());
    see_issue("rstmid");
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 16'(cordic_valid), 16'h0);
    check("rstmid_busy",  16'(busy),         16'h0);
    #1 rst_n = 1'b1;
    respond(16'h1234, 1);
    repeat (2) @(negedge clk);
    check("rstmid_busy2", 16'(busy), 16'h0);
    bus_read(2'd2, d); check("rstmid_status", d, 16'h0000);
    bus_read(2'd3, d); check("rstmid_result", d, 16'h0000);

    // Interrupt (enable bit 9 set)
`ifdef CORDIC_CMD_IRQ_EN
    irq_stat = 16'h0009;
`else
    irq_stat = 16'h0001;
`endif
    start_cmd(16'd0, 16'd0, 16'h0301, op_t'{16'd0, 16'd0, 4'b0001}, 16'h0040);
    see_issue("irq"); respond(16'h0040, 1); finish_cmd("irq", irq_stat);
    check("irq_level", 16'(irq), {15'b0, irq_stat[3]});
    bus_write(2'd2, 16'h8000);
    check("irq_clear", 16'(irq), 16'h0);
    bus_read(2'd2, d); check("irq_status_clr", d, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
